// File: rtl/mem_stage_lsu.sv
// Memory-stage load/store unit with dmem request/ready handshake and MEM/WB pipeline register.
// Stalls upstream while a data-memory access is outstanding.
module mem_stage_lsu (
  input  logic        clk,
  input  logic        rst,
  input  logic        MemRead_mem,
  input  logic        MemWrite_mem,
  input  logic        MemtoReg_mem,
  input  logic        RegWrite_mem,
  input  logic [2:0]  funct3_mem,
  input  logic [4:0]  rd_mem,
  input  logic [31:0] ALUResult_mem,
  input  logic [31:0] rs2Data_mem,
  input  logic        flush_mem,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_wstrb,
  input  logic        dmem_ready,
  input  logic [31:0] dmem_rdata,
  output logic        stall_mem,
  output logic        MemtoReg_wb,
  output logic        RegWrite_wb,
  output logic [4:0]  rd_wb,
  output logic [31:0] ALUResult_wb,
  output logic [31:0] memDout_wb,
  output logic        err_wb
);

  typedef enum logic [0:0] {StIdle, StWait} state_e;

  state_e      state_q, state_d;
  logic [31:0] addr_q, addr_d, wdata_q, wdata_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic        we_q, we_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [1:0]  lane_q, lane_d;

  logic        memtoreg_wb_q, memtoreg_wb_d, regwrite_wb_q, regwrite_wb_d, err_wb_q, err_wb_d;
  logic [4:0]  rd_wb_q, rd_wb_d;
  logic [31:0] alu_wb_q, alu_wb_d, dout_wb_q, dout_wb_d;

  logic        in_wait, any_mem, mem_op, legal, aligned, issue, acc_err, is_load_cur;
  logic [1:0]  lane_in, ld_lane;
  logic [2:0]  ld_f3;
  logic [31:0] fmt_wdata, shifted, ld_data;
  logic [3:0]  fmt_wstrb;

  always_comb begin
    in_wait = (state_q == StWait);
    lane_in = ALUResult_mem[1:0];
    any_mem = MemRead_mem | MemWrite_mem;
    mem_op  = any_mem & ~flush_mem;
    legal   = MemRead_mem ? (funct3_mem inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101})
                          : (funct3_mem inside {3'b000, 3'b001, 3'b010});
    case (funct3_mem[1:0])
      2'b01:   aligned = ~lane_in[0];
      2'b10:   aligned = (lane_in == 2'b00);
      default: aligned = 1'b1;
    endcase
    issue   = ~in_wait & mem_op & legal & aligned;
    acc_err = ~in_wait & any_mem & ~(legal & aligned);

    // Lane replication lets the memory pick bytes purely by strobe.
    case (funct3_mem[1:0])
      2'b00: begin
        fmt_wdata = {4{rs2Data_mem[7:0]}};
        fmt_wstrb = 4'b0001 << lane_in;
      end
      2'b01: begin
        fmt_wdata = {2{rs2Data_mem[15:0]}};
        fmt_wstrb = 4'b0011 << lane_in;
      end
      default: begin
        fmt_wdata = rs2Data_mem;
        fmt_wstrb = 4'b1111;
      end
    endcase
    if (MemRead_mem) begin
      fmt_wdata = '0;
      fmt_wstrb = '0;
    end

    dmem_req   = in_wait | issue;
    dmem_we    = in_wait ? we_q    : ~MemRead_mem;
    dmem_addr  = in_wait ? addr_q  : {ALUResult_mem[31:2], 2'b00};
    dmem_wdata = in_wait ? wdata_q : fmt_wdata;
    dmem_wstrb = in_wait ? wstrb_q : fmt_wstrb;
    stall_mem  = dmem_req & ~dmem_ready;

    ld_f3       = in_wait ? funct3_q : funct3_mem;
    ld_lane     = in_wait ? lane_q   : lane_in;
    is_load_cur = in_wait ? ~we_q    : MemRead_mem;
    shifted     = dmem_rdata >> {ld_lane, 3'b000};
    case (ld_f3)
      3'b000:  ld_data = {{24{shifted[7]}}, shifted[7:0]};
      3'b001:  ld_data = {{16{shifted[15]}}, shifted[15:0]};
      3'b100:  ld_data = {24'd0, shifted[7:0]};
      3'b101:  ld_data = {16'd0, shifted[15:0]};
      default: ld_data = shifted;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    wstrb_d  = wstrb_q;
    we_d     = we_q;
    funct3_d = funct3_q;
    lane_d   = lane_q;
    unique case (state_q)
      StIdle: begin
        if (issue) begin
          addr_d   = dmem_addr;
          wdata_d  = fmt_wdata;
          wstrb_d  = fmt_wstrb;
          we_d     = ~MemRead_mem;
          funct3_d = funct3_mem;
          lane_d   = lane_in;
          if (!dmem_ready) state_d = StWait;
        end
      end
      StWait: if (dmem_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    memtoreg_wb_d = memtoreg_wb_q;
    regwrite_wb_d = regwrite_wb_q;
    err_wb_d      = err_wb_q;
    rd_wb_d       = rd_wb_q;
    alu_wb_d      = alu_wb_q;
    dout_wb_d     = dout_wb_q;
    if (stall_mem || (!in_wait && flush_mem)) begin
      memtoreg_wb_d = 1'b0;
      regwrite_wb_d = 1'b0;
      err_wb_d      = 1'b0;
    end else begin
      memtoreg_wb_d = MemtoReg_mem;
      regwrite_wb_d = RegWrite_mem & ~acc_err;
      err_wb_d      = acc_err;
      rd_wb_d       = rd_mem;
      alu_wb_d      = ALUResult_mem;
      dout_wb_d     = (is_load_cur && !acc_err) ? ld_data : 32'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= StIdle;
      addr_q        <= '0;
      wdata_q       <= '0;
      wstrb_q       <= '0;
      we_q          <= 1'b0;
      funct3_q      <= '0;
      lane_q        <= '0;
      memtoreg_wb_q <= 1'b0;
      regwrite_wb_q <= 1'b0;
      err_wb_q      <= 1'b0;
      rd_wb_q       <= '0;
      alu_wb_q      <= '0;
      dout_wb_q     <= '0;
    end else begin
      state_q       <= state_d;
      addr_q        <= addr_d;
      wdata_q       <= wdata_d;
      wstrb_q       <= wstrb_d;
      we_q          <= we_d;
      funct3_q      <= funct3_d;
      lane_q        <= lane_d;
      memtoreg_wb_q <= memtoreg_wb_d;
      regwrite_wb_q <= regwrite_wb_d;
      err_wb_q      <= err_wb_d;
      rd_wb_q       <= rd_wb_d;
      alu_wb_q      <= alu_wb_d;
      dout_wb_q     <= dout_wb_d;
    end
  end

  assign MemtoReg_wb  = memtoreg_wb_q;
  assign RegWrite_wb  = regwrite_wb_q;
  assign err_wb       = err_wb_q;
  assign rd_wb        = rd_wb_q;
  assign ALUResult_wb = alu_wb_q;
  assign memDout_wb   = dout_wb_q;

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Scoreboard bench for mem_stage_lsu: the driver plays the data memory from a byte-array model
// and queues the expected MEM/WB contents per cycle; a monitor pops and compares after each edge.
module tb_mem_stage_lsu;

  logic        clk = 1'b0;
  logic        rst;
  logic        MemRead_mem, MemWrite_mem, MemtoReg_mem, RegWrite_mem, flush_mem;
  logic [2:0]  funct3_mem;
  logic [4:0]  rd_mem;
  logic [31:0] ALUResult_mem, rs2Data_mem;
  logic        dmem_req, dmem_we, dmem_ready, stall_mem;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [3:0]  dmem_wstrb;
  logic        MemtoReg_wb, RegWrite_wb, err_wb;
  logic [4:0]  rd_wb;
  logic [31:0] ALUResult_wb, memDout_wb;

  mem_stage_lsu dut (
    .clk(clk), .rst(rst),
    .MemRead_mem(MemRead_mem), .MemWrite_mem(MemWrite_mem), .MemtoReg_mem(MemtoReg_mem),
    .RegWrite_mem(RegWrite_mem), .funct3_mem(funct3_mem), .rd_mem(rd_mem),
    .ALUResult_mem(ALUResult_mem), .rs2Data_mem(rs2Data_mem), .flush_mem(flush_mem),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_wstrb(dmem_wstrb), .dmem_ready(dmem_ready), .dmem_rdata(dmem_rdata),
    .stall_mem(stall_mem), .MemtoReg_wb(MemtoReg_wb), .RegWrite_wb(RegWrite_wb),
    .rd_wb(rd_wb), .ALUResult_wb(ALUResult_wb), .memDout_wb(memDout_wb), .err_wb(err_wb)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          full;
    logic        mtr, rw, err;
    logic [4:0]  rd;
    logic [31:0] alu, dout;
  } wb_t;

  wb_t        exp_q[$];
  wb_t        mon_e;
  logic [7:0] mem [1024];
  int         n_tests = 0;
  int         n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic wb_t mk(input bit full, input logic mtr, input logic rw, input logic err,
                             input logic [4:0] rd, input logic [31:0] alu, input logic [31:0] dout);
    wb_t r;
    r.full = full; r.mtr = mtr; r.rw = rw; r.err = err; r.rd = rd; r.alu = alu; r.dout = dout;
    return r;
  endfunction

  function automatic logic [31:0] word_at(input int a);
    int w = a & ~3;
    return {mem[w+3], mem[w+2], mem[w+1], mem[w]};
  endfunction

  function automatic logic [31:0] load_val(input int a, input logic [2:0] f3);
    int size = 1 << f3[1:0];
    logic [31:0] v = 32'd0;
    for (int j = 0; j < size; j++) v = v | (32'(mem[a+j]) << (8 * j));
    if (!f3[2] && size < 4 && v[8*size-1]) v = v | (32'hFFFF_FFFF << (8 * size));
    return v;
  endfunction

  task automatic set_word(input int a, input logic [31:0] w);
    for (int j = 0; j < 4; j++) mem[a+j] = w[8*j +: 8];
  endtask

  // One instruction in the MEM stage; k = wait cycles the memory inserts before ready.
  task automatic do_op(input logic mr, input logic mw, input logic mtr, input logic rw,
                       input logic [2:0] f3, input logic [4:0] rd, input logic [31:0] alu,
                       input logic [31:0] rs2, input int k, input bit fl0, input bit flw);
    int  size    = 1 << f3[1:0];
    int  off     = int'(alu[1:0]);
    int  a       = int'(alu[9:0]);
    bit  is_mem  = mr || mw;
    bit  legal   = mr ? (f3 != 3 && f3 != 6 && f3 != 7) : (f3 <= 2);
    bit  aligned = (off % size) == 0;
    bit  issue   = is_mem && !fl0 && legal && aligned;
    bit  err     = is_mem && !(legal && aligned);
    logic [3:0]  e_strb;
    logic [31:0] e_wdata;
    @(posedge clk); #1;
    MemRead_mem = mr; MemWrite_mem = mw; MemtoReg_mem = mtr; RegWrite_mem = rw;
    funct3_mem = f3; rd_mem = rd; ALUResult_mem = alu; rs2Data_mem = rs2; flush_mem = fl0;
    if (!issue) begin
      dmem_ready = 1'($urandom % 2);
      dmem_rdata = $urandom;
      if (fl0 && is_mem) exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 0));
      else exp_q.push_back(mk(1, mtr, rw && !err, err, rd, alu, 32'd0));
      @(negedge clk);
      check("noreq_req", 32'(dmem_req), 32'd0);
      check("noreq_stall", 32'(stall_mem), 32'd0);
    end else begin
      for (int i = 0; i < 4; i++) begin
        e_strb[i]         = mw && (i >= off) && (i < off + size);
        e_wdata[8*i +: 8] = rs2[8*(i % size) +: 8];
      end
      for (int c = 0; c <= k; c++) begin
        if (c > 0) begin
          @(posedge clk); #1;
          flush_mem = flw;
        end
        dmem_ready = (c == k);
        dmem_rdata = mr ? word_at(a) : $urandom;
        if (c < k) exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 0));
        else exp_q.push_back(mk(1, mtr, rw, 0, rd, alu, mr ? load_val(a, f3) : 32'd0));
        @(negedge clk);
        check("req", 32'(dmem_req), 32'd1);
        check("we", 32'(dmem_we), 32'(mw));
        check("addr", dmem_addr, alu & ~32'd3);
        check("wstrb", 32'(dmem_wstrb), 32'(e_strb));
        if (mw) check("wdata", dmem_wdata, e_wdata);
        check("stall", 32'(stall_mem), 32'(c < k));
      end
      if (mw) for (int i = 0; i < 4; i++) if (e_strb[i]) mem[(a & ~3) + i] = e_wdata[8*i +: 8];
    end
  endtask

  always @(posedge clk) begin
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      #2;
      check("wb_regwrite", 32'(RegWrite_wb), 32'(mon_e.rw));
      check("wb_memtoreg", 32'(MemtoReg_wb), 32'(mon_e.mtr));
      check("wb_err", 32'(err_wb), 32'(mon_e.err));
      if (mon_e.full) begin
        check("wb_rd", 32'(rd_wb), 32'(mon_e.rd));
        check("wb_alu", ALUResult_wb, mon_e.alu);
        check("wb_dout", memDout_wb, mon_e.dout);
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 8'($urandom);
    rst = 1'b1;
    MemRead_mem = 0; MemWrite_mem = 0; MemtoReg_mem = 0; RegWrite_mem = 0; flush_mem = 0;
    funct3_mem = 0; rd_mem = 0; ALUResult_mem = 0; rs2Data_mem = 0;
    dmem_ready = 0; dmem_rdata = 0;
    exp_q.push_back(mk(1, 0, 0, 0, 0, 0, 0));
    @(posedge clk); #1;
    rst = 1'b0;
    exp_q.push_back(mk(1, 0, 0, 0, 0, 0, 0));

    set_word(32'h100, 32'hDEAD_BEEF);
    do_op(1, 0, 1, 1, 3'b010, 5'd5, 32'h100, 32'd0, 0, 0, 0);
    set_word(32'h100, 32'h80FF_0000);
    do_op(1, 0, 1, 1, 3'b000, 5'd6, 32'h103, 32'd0, 0, 0, 0);
    do_op(1, 0, 1, 1, 3'b100, 5'd7, 32'h103, 32'd0, 0, 0, 0);
    do_op(1, 0, 1, 1, 3'b101, 5'd8, 32'h102, 32'd0, 0, 0, 0);
    do_op(0, 1, 0, 0, 3'b001, 5'd0, 32'h202, 32'h1234_ABCD, 3, 0, 0);
    do_op(1, 0, 1, 1, 3'b010, 5'd9, 32'h101, 32'd0, 0, 0, 0);
    do_op(0, 1, 0, 0, 3'b010, 5'd0, 32'h040, 32'hCAFE_F00D, 2, 1, 0);
    do_op(0, 1, 0, 0, 3'b010, 5'd0, 32'h044, 32'h5566_7788, 3, 0, 1);
    do_op(1, 0, 1, 1, 3'b010, 5'd10, 32'h044, 32'd0, 1, 0, 1);
    do_op(0, 0, 0, 1, 3'b000, 5'd11, 32'h1357_9BDF, 32'd0, 0, 0, 0);

    for (int n = 0; n < 300; n++) begin
      int kind = int'($urandom % 4);
      logic mr = (kind == 1 || kind == 3);
      logic mw = (kind == 2);
      logic [31:0] alu = (mr || mw) ? 32'($urandom % 1024) : $urandom;
      do_op(mr, mw, 1'($urandom), 1'($urandom), 3'($urandom), 5'($urandom), alu, $urandom,
            int'($urandom % 4), ($urandom % 8) == 0, 1'($urandom));
    end

    // Reset while a load is waiting; the ready that arrives with reset must be ignored.
    @(posedge clk); #1;
    MemRead_mem = 1; MemWrite_mem = 0; MemtoReg_mem = 1; RegWrite_mem = 1; flush_mem = 0;
    funct3_mem = 3'b010; rd_mem = 5'd12; ALUResult_mem = 32'h10; dmem_ready = 0;
    exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 0));
    @(negedge clk);
    check("rstw_req", 32'(dmem_req), 32'd1);
    check("rstw_stall", 32'(stall_mem), 32'd1);
    @(posedge clk); #1;
    exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 0));
    @(negedge clk);
    check("rstw_stall2", 32'(stall_mem), 32'd1);
    @(posedge clk); #1;
    rst = 1'b1; dmem_ready = 1; dmem_rdata = 32'hFFFF_FFFF;
    exp_q.push_back(mk(1, 0, 0, 0, 0, 0, 0));
    @(posedge clk); #1;
    rst = 1'b0;
    MemRead_mem = 0; MemtoReg_mem = 0; RegWrite_mem = 0; funct3_mem = 0; rd_mem = 0;
    ALUResult_mem = 0; dmem_ready = 1;
    exp_q.push_back(mk(1, 0, 0, 0, 0, 0, 0));
    @(negedge clk);
    check("post_rst_req", 32'(dmem_req), 32'd0);
    check("post_rst_stall", 32'(stall_mem), 32'd0);
    @(posedge clk); #1;
    dmem_ready = 0;
    exp_q.push_back(mk(1, 0, 0, 0, 0, 0, 0));

    repeat (3) @(posedge clk);
    #3;
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
